// File: rtl/surf_scaler_bank.sv
// Per-channel trigger scaler bank: counts rising edges per gate, snapshots into a shadow buffer,
// and hands that to a read-stable holding buffer. Optional external gate: define SCAL_GATE_EXT_EN.
module surf_scaler_bank #(
   parameter int NUM_CH      = 32,
   parameter int CNT_WIDTH   = 16,
   parameter int GATE_CYCLES = 33000000
) (
   input  logic                 clk_i,
   input  logic                 nrst_i,
   input  logic                 clr_i,
   input  logic [NUM_CH-1:0]    trig_i,
   input  logic [NUM_CH-1:0]    mask_i,
   input  logic                 refpulse_i,
   input  logic [4:0]           scal_addr_i,
   input  logic                 scal_rd_i,
`ifdef SCAL_GATE_EXT_EN
   input  logic                 gate_i,
`endif
   output logic [CNT_WIDTH-1:0] scal_dat_o,
   output logic [CNT_WIDTH-1:0] refpulse_cnt_o,
   output logic                 gate_done_o,
   output logic                 rd_busy_o
);

   typedef enum logic {ST_COUNT = 1'b0, ST_SNAP = 1'b1} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [4:0]           ADDR_LAST = 5'(NUM_CH - 1);

   state_t                state_q, state_d;
   logic [NUM_CH-1:0]     trig_d_q, trig_d_d;
   logic                  ref_d_q, ref_d_d;
   logic [CNT_WIDTH-1:0]  cnt_q [NUM_CH];
   logic [CNT_WIDTH-1:0]  cnt_d [NUM_CH];
   logic [CNT_WIDTH-1:0]  shadow_q [NUM_CH];
   logic [CNT_WIDTH-1:0]  shadow_d [NUM_CH];
   logic [CNT_WIDTH-1:0]  hold_q [NUM_CH];
   logic [CNT_WIDTH-1:0]  hold_d [NUM_CH];
   logic [CNT_WIDTH-1:0]  ref_cnt_q, ref_cnt_d;
   logic [CNT_WIDTH-1:0]  ref_sh_q, ref_sh_d;
   logic [CNT_WIDTH-1:0]  ref_hold_q, ref_hold_d;
   logic                  pend_q, pend_d;
   logic                  busy_q, busy_d;

   logic [NUM_CH-1:0]     trig_edge;
   logic                  ref_edge;
   logic                  snap;
   logic                  xfer;

`ifdef SCAL_GATE_EXT_EN
   logic                  gate_d_q, gate_d_d;
   logic                  gate_edge;

   assign gate_edge = gate_i & ~gate_d_q;
   assign gate_d_d  = clr_i ? 1'b0 : gate_i;
`else
   localparam int                TW         = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [TW-1:0]     TIMER_LAST = TW'(GATE_CYCLES - 1);

   logic [TW-1:0]         timer_q, timer_d;
`endif

   // Gate FSM: COUNT accumulates, SNAP is the single cycle that closes a gate.
   always_comb begin
      state_d     = state_q;
      gate_done_o = 1'b0;
`ifdef SCAL_GATE_EXT_EN
      case (state_q)
         ST_COUNT: if (gate_edge) state_d = ST_SNAP;
         ST_SNAP: begin
            gate_done_o = 1'b1;
            state_d     = gate_edge ? ST_SNAP : ST_COUNT;
         end
         default: state_d = ST_COUNT;
      endcase
      if (clr_i) state_d = ST_COUNT;
`else
      timer_d = timer_q;
      case (state_q)
         ST_COUNT: begin
            timer_d = timer_q + 1'b1;
            if (timer_d == TIMER_LAST) state_d = ST_SNAP;
         end
         ST_SNAP: begin
            gate_done_o = 1'b1;
            timer_d     = '0;
            state_d     = ST_COUNT;
         end
         default: state_d = ST_COUNT;
      endcase
      if (clr_i) begin
         state_d = ST_COUNT;
         timer_d = '0;
      end
`endif
   end

   assign trig_edge = trig_i & ~trig_d_q;
   assign ref_edge  = refpulse_i & ~ref_d_q;
   assign snap      = (state_q == ST_SNAP);
   // A snapshot landing in the shadow outranks a transfer in the same cycle.
   assign xfer      = pend_q & ~busy_q & ~snap;

   always_comb begin
      trig_d_d   = trig_i;
      ref_d_d    = refpulse_i;
      ref_sh_d   = snap ? ref_cnt_q : ref_sh_q;
      ref_hold_d = xfer ? ref_sh_q : ref_hold_q;
      ref_cnt_d  = snap ? CNT_WIDTH'(ref_edge) : ref_cnt_q + CNT_WIDTH'(ref_edge);
      pend_d     = snap ? 1'b1 : (xfer ? 1'b0 : pend_q);
      busy_d     = busy_q;
      if (scal_rd_i && scal_addr_i == ADDR_LAST) busy_d = 1'b0;
      else if (scal_rd_i && scal_addr_i == 5'd0) busy_d = 1'b1;

      for (int i = 0; i < NUM_CH; i++) begin
         shadow_d[i] = snap ? cnt_q[i] : shadow_q[i];
         hold_d[i]   = xfer ? shadow_q[i] : hold_q[i];
         if (mask_i[i])                            cnt_d[i] = '0;
         else if (snap)                            cnt_d[i] = CNT_WIDTH'(trig_edge[i]);
         else if (trig_edge[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
         else                                      cnt_d[i] = cnt_q[i];
      end

      if (clr_i) begin
         trig_d_d   = '0;
         ref_d_d    = 1'b0;
         ref_sh_d   = '0;
         ref_hold_d = '0;
         ref_cnt_d  = '0;
         pend_d     = 1'b0;
         busy_d     = 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = '0;
            hold_d[i]   = '0;
            cnt_d[i]    = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q    <= ST_COUNT;
         trig_d_q   <= '0;
         ref_d_q    <= 1'b0;
         ref_cnt_q  <= '0;
         ref_sh_q   <= '0;
         ref_hold_q <= '0;
         pend_q     <= 1'b0;
         busy_q     <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]    <= '0;
            shadow_q[i] <= '0;
            hold_q[i]   <= '0;
         end
`ifdef SCAL_GATE_EXT_EN
         gate_d_q   <= 1'b0;
`else
         timer_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         trig_d_q   <= trig_d_d;
         ref_d_q    <= ref_d_d;
         ref_cnt_q  <= ref_cnt_d;
         ref_sh_q   <= ref_sh_d;
         ref_hold_q <= ref_hold_d;
         pend_q     <= pend_d;
         busy_q     <= busy_d;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]    <= cnt_d[i];
            shadow_q[i] <= shadow_d[i];
            hold_q[i]   <= hold_d[i];
         end
`ifdef SCAL_GATE_EXT_EN
         gate_d_q   <= gate_d_d;
`else
         timer_q    <= timer_d;
`endif
      end
   end

   // Addresses without a channel behind them read as zero.
   always_comb begin
      scal_dat_o = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (scal_addr_i == 5'(i)) scal_dat_o = hold_q[i];
      end
   end

   assign refpulse_cnt_o = ref_hold_q;
   assign rd_busy_o      = busy_q;

endmodule

// File: tb/tb_surf_scaler_bank.sv
// Bench for surf_scaler_bank: short gate, 4-bit counters, randomized triggers against a
// gate-level behavioural model of counts, snapshots, readout lock and clears.
module tb_surf_scaler_bank;

   localparam int NCH  = 32;
   localparam int CW   = 4;
   localparam int GC   = 100;
   localparam int CMAX = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            nrst;
   logic            clr = 1'b0;
   logic [NCH-1:0]  trig = '0;
   logic [NCH-1:0]  mask = '0;
   logic            refp = 1'b0;
   logic [4:0]      addr = '0;
   logic            rd = 1'b0;
   logic [CW-1:0]   dat;
   logic [CW-1:0]   refcnt;
   logic            gdone;
   logic            busy;

   int errors = 0;
   int checks = 0;

   // Behavioural model: counts accumulated during the current gate, the last closed gate
   // (shadow), the gate the reader sees (hold), and the position inside the gate.
   int              m_cnt  [NCH];
   int              m_sh   [NCH];
   int              m_hold [NCH];
   int              m_ref, m_ref_sh, m_ref_hold;
   bit              m_pend, m_busy;
   logic [NCH-1:0]  m_prev;
   bit              m_prev_ref;
   int              m_phase;

   always #5 clk = ~clk;

   surf_scaler_bank #(.NUM_CH(NCH), .CNT_WIDTH(CW), .GATE_CYCLES(GC)) dut (
      .clk_i          (clk),
      .nrst_i         (nrst),
      .clr_i          (clr),
      .trig_i         (trig),
      .mask_i         (mask),
      .refpulse_i     (refp),
      .scal_addr_i    (addr),
      .scal_rd_i      (rd),
      .scal_dat_o     (dat),
      .refpulse_cnt_o (refcnt),
      .gate_done_o    (gdone),
      .rd_busy_o      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_cnt[i]  = 0;
         m_sh[i]   = 0;
         m_hold[i] = 0;
      end
      m_ref = 0; m_ref_sh = 0; m_ref_hold = 0;
      m_pend = 0; m_busy = 0;
      m_prev = '0; m_prev_ref = 0;
      m_phase = 0;
   endtask

   // One clock cycle of behaviour, given the inputs currently applied.
   task automatic model_step();
      logic [NCH-1:0] e;
      bit re, closing, moving;
      if (clr) begin
         model_reset();
         return;
      end
      e       = trig & ~m_prev;
      re      = refp & ~m_prev_ref;
      closing = (m_phase == GC - 1);
      moving  = m_pend && !m_busy && !closing;
      if (moving) begin
         m_hold     = m_sh;
         m_ref_hold = m_ref_sh;
      end
      if (closing) begin
         m_sh     = m_cnt;
         m_ref_sh = m_ref;
      end
      for (int i = 0; i < NCH; i++) begin
         if (mask[i])      m_cnt[i] = 0;
         else if (closing) m_cnt[i] = int'(e[i]);
         else if (e[i])    m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
      end
      m_ref  = closing ? int'(re) : (m_ref + int'(re)) % (CMAX + 1);
      m_pend = closing ? 1'b1 : (moving ? 1'b0 : m_pend);
      if (rd && int'(addr) == NCH - 1) m_busy = 0;
      else if (rd && addr == 5'd0)     m_busy = 1;
      m_prev     = trig;
      m_prev_ref = refp;
      m_phase    = (m_phase + 1) % GC;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("gate_done", 32'(gdone), 32'(m_phase == GC - 1));
      chk("rd_busy", 32'(busy), 32'(m_busy));
      chk("refpulse_cnt", 32'(refcnt), 32'(m_ref_hold));
      chk("scal_dat", 32'(dat), 32'(m_hold[addr]));
   endtask

   function automatic logic [NCH-1:0] sparse_rnd();
      return NCH'($urandom & $urandom & $urandom);
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first_done;
      logic [NCH-1:0] t;

      // Reset: everything reads zero.
      nrst = 1'b1;
      #1 nrst = 1'b0;
      model_reset();
      #11;
      chk("rst_dat", 32'(dat), 32'd0);
      chk("rst_ref", 32'(refcnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gdone", 32'(gdone), 32'd0);
      nrst = 1'b1;

      // Gate 1: ch0 saturates, ch3 edge every 8, ch4/ch5 same stimulus with ch5 masked,
      // ch7 and refpulse rise exactly on the snapshot cycle.
      mask = NCH'(1) << 5;
      for (int c = 0; c < GC; c++) begin
         t    = sparse_rnd();
         t[0] = c[0];
         t[3] = ((c / 4) % 2) == 1;
         t[4] = (c % 3) == 1;
         t[5] = (c % 3) == 1;
         t[7] = (c == GC - 1);
         trig = t;
         refp = (c >= GC - 2) ? (c == GC - 1) : 1'($urandom_range(0, 1));
         tick();
      end

      // Gate 2: read every address, then lock the holding buffer with an addr-0 strobe.
      for (int c = 0; c < GC; c++) begin
         t    = sparse_rnd();
         t[7] = 1'b1;
         trig = t;
         refp = 1'b1;
         rd   = (c == 40);
         addr = (c >= 1 && c <= NCH) ? 5'(c - 1) : 5'd0;
         tick();
         if (c == 1) chk("ch0_saturated", 32'(dat), 32'(CMAX));
         if (c == 4) chk("ch3_edge_count", 32'(dat == 4'd12 || dat == 4'd13), 32'd1);
         if (c == 5) chk("ch4_nonzero", 32'(dat != '0), 32'd1);
         if (c == 6) chk("ch5_masked", 32'(dat), 32'd0);
         if (c == 8) chk("ch7_old_gate", 32'(dat), 32'd0);
      end
      rd = 1'b0;

      // Gate 3: holding stays on gate 1 until the addr-31 strobe, then gate 2 appears.
      for (int c = 0; c < GC; c++) begin
         t    = sparse_rnd();
         t[7] = 1'b1;
         trig = t;
         refp = 1'b1;
         rd   = (c == NCH - 1) || (c == 40);
         if (c < NCH - 1)                   addr = 5'(c + 1);
         else if (c == NCH - 1)             addr = 5'(NCH - 1);
         else if (c == NCH || c == NCH + 1) addr = 5'd7;
         else if (c == 40)                  addr = 5'd0;
         else                               addr = 5'($urandom_range(1, NCH - 2));
         tick();
         if (c == 6)   chk("ch7_locked_old", 32'(dat), 32'd0);
         if (c == NCH) begin
            chk("ch7_new_gate", 32'(dat), 32'd1);
            chk("ref_new_gate", 32'(refcnt), 32'd1);
         end
      end
      rd = 1'b0;

      // Gate 4: pend is held by the lock; clear mid-gate.
      for (int c = 0; c < 10; c++) begin
         trig = sparse_rnd();
         refp = 1'($urandom_range(0, 1));
         addr = 5'($urandom_range(1, NCH - 2));
         tick();
      end
      chk("pend_before_clr", 32'(m_pend), 32'd1);
      clr  = 1'b1;
      trig = sparse_rnd();
      addr = 5'd3;
      tick();
      clr = 1'b0;
      chk("clr_dat", 32'(dat), 32'd0);
      chk("clr_ref", 32'(refcnt), 32'd0);
      chk("clr_busy", 32'(busy), 32'd0);

      // Timer restarts at the clear: next snapshot GC-1 cycles after it.
      first_done = -1;
      for (int i = 0; i < 120; i++) begin
         trig = sparse_rnd();
         refp = 1'($urandom_range(0, 1));
         rd   = (i == 10);
         addr = (i == 10) ? 5'd0 : 5'(i % NCH);
         tick();
         if (gdone && first_done < 0) first_done = i + 1;
      end
      rd = 1'b0;
      chk("gate_restart", 32'(first_done), 32'(GC - 1));

      // Asynchronous reset between clock edges.
      #2 nrst = 1'b0;
      #1;
      model_reset();
      chk("arst_dat", 32'(dat), 32'd0);
      chk("arst_ref", 32'(refcnt), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_gdone", 32'(gdone), 32'd0);
      #1 nrst = 1'b1;

      // Free-running random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         trig = sparse_rnd();
         refp = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) mask = NCH'($urandom & $urandom);
         rd   = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 2))
            0:       addr = 5'd0;
            1:       addr = 5'(NCH - 1);
            default: addr = 5'($urandom_range(0, NCH - 1));
         endcase
         clr  = ($urandom_range(0, 199) == 0);
         tick();
      end
      clr = 1'b0;
      rd  = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
